// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control: FETCH/DECODE/EXEC/MEM/WB sequencer with trap and retire count.
// Latency: strobes are combinational from registered state; branch 3, lw 5, others 4 cycles at zero wait.
// Backpressure: mem_req and the address select are held until mem_ready, with an optional timeout to TRAP.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Op,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [5:0]       EXTOp,
    output logic [4:0]       ALUOp,
    output logic [2:0]       NPCOp,
    output logic             ALUSrc,
    output logic [1:0]       WDSel,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [4:0] ALU_NOP = 5'd0,  ALU_LUI = 5'd1,  ALU_AUIPC = 5'd2, ALU_ADD = 5'd3;
    localparam logic [4:0] ALU_SUB = 5'd4,  ALU_BNE = 5'd5,  ALU_BLT = 5'd6,   ALU_BGE = 5'd7;
    localparam logic [4:0] ALU_BLTU = 5'd8, ALU_BGEU = 5'd9, ALU_SLT = 5'd10,  ALU_SLTU = 5'd11;
    localparam logic [4:0] ALU_XOR = 5'd12, ALU_OR = 5'd13,  ALU_AND = 5'd14,  ALU_SLL = 5'd15;
    localparam logic [4:0] ALU_SRL = 5'd16, ALU_SRA = 5'd17;

    localparam logic [5:0] EXT_NONE = 6'b000000, EXT_SHAMT = 6'b100000, EXT_I = 6'b010000;
    localparam logic [5:0] EXT_S = 6'b001000, EXT_B = 6'b000100, EXT_U = 6'b000010, EXT_J = 6'b000001;

    // Wide enough to hold MEM_TIMEOUT-1; with no timeout it simply saturates.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   retired_q;

    logic legal, is_lw, is_sw, is_br, is_jal, is_jalr;
    logic timeout_hit;

    // Instruction decode from the IR fields; independent of state.
    always_comb begin
        legal   = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_br   = 1'b0;
        is_jal  = 1'b0;
        is_jalr = 1'b0;
        EXTOp   = EXT_NONE;
        ALUOp   = ALU_NOP;
        ALUSrc  = 1'b0;
        unique case (Op)
            OP_R: begin
                legal = 1'b1;
                case ({Funct7, Funct3})
                    {7'h00, 3'h0}: ALUOp = ALU_ADD;
                    {7'h20, 3'h0}: ALUOp = ALU_SUB;
                    {7'h00, 3'h1}: ALUOp = ALU_SLL;
                    {7'h00, 3'h2}: ALUOp = ALU_SLT;
                    {7'h00, 3'h3}: ALUOp = ALU_SLTU;
                    {7'h00, 3'h4}: ALUOp = ALU_XOR;
                    {7'h00, 3'h5}: ALUOp = ALU_SRL;
                    {7'h20, 3'h5}: ALUOp = ALU_SRA;
                    {7'h00, 3'h6}: ALUOp = ALU_OR;
                    {7'h00, 3'h7}: ALUOp = ALU_AND;
                    default:       legal = 1'b0;
                endcase
            end
            OP_I: begin
                legal  = 1'b1;
                ALUSrc = 1'b1;
                EXTOp  = EXT_I;
                case (Funct3)
                    3'h0: ALUOp = ALU_ADD;
                    3'h2: ALUOp = ALU_SLT;
                    3'h3: ALUOp = ALU_SLTU;
                    3'h4: ALUOp = ALU_XOR;
                    3'h6: ALUOp = ALU_OR;
                    3'h7: ALUOp = ALU_AND;
                    3'h1: begin
                        EXTOp = EXT_SHAMT;
                        ALUOp = ALU_SLL;
                        legal = (Funct7 == 7'h00);
                    end
                    default: begin
                        EXTOp = EXT_SHAMT;
                        ALUOp = (Funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        legal = (Funct7 == 7'h00) || (Funct7 == 7'h20);
                    end
                endcase
            end
            OP_LW: begin
                legal  = (Funct3 == 3'b010);
                is_lw  = legal;
                EXTOp  = EXT_I;
                ALUOp  = ALU_ADD;
                ALUSrc = 1'b1;
            end
            OP_SW: begin
                legal  = (Funct3 == 3'b010);
                is_sw  = legal;
                EXTOp  = EXT_S;
                ALUOp  = ALU_ADD;
                ALUSrc = 1'b1;
            end
            OP_BR: begin
                legal = 1'b1;
                is_br = 1'b1;
                EXTOp = EXT_B;
                case (Funct3)
                    3'h0:    ALUOp = ALU_SUB;
                    3'h1:    ALUOp = ALU_BNE;
                    3'h4:    ALUOp = ALU_BLT;
                    3'h5:    ALUOp = ALU_BGE;
                    3'h6:    ALUOp = ALU_BLTU;
                    3'h7:    ALUOp = ALU_BGEU;
                    default: begin
                        legal = 1'b0;
                        is_br = 1'b0;
                    end
                endcase
            end
            OP_JAL: begin
                legal  = 1'b1;
                is_jal = 1'b1;
                EXTOp  = EXT_J;
                ALUOp  = ALU_ADD;
            end
            OP_JALR: begin
                legal   = (Funct3 == 3'b000);
                is_jalr = legal;
                EXTOp   = EXT_I;
                ALUOp   = ALU_ADD;
                ALUSrc  = 1'b1;
            end
            OP_LUI: begin
                legal  = 1'b1;
                EXTOp  = EXT_U;
                ALUOp  = ALU_LUI;
                ALUSrc = 1'b1;
            end
            OP_AUIPC: begin
                legal  = 1'b1;
                EXTOp  = EXT_U;
                ALUOp  = ALU_AUIPC;
                ALUSrc = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Write-data select only matters in WB, but is harmless to decode always.
    always_comb begin
        WDSel = 2'b00;
        if (is_lw)
            WDSel = 2'b01;
        else if (is_jal || is_jalr)
            WDSel = 2'b10;
    end

    // The limit cycle only trips if ready is absent; ready on that cycle completes the access.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                         (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state and state-gated strobes; everything forced quiet while rst is high.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        mem_req  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        NPCOp    = 3'b000;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    cause_d = 2'b10;
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    cause_d = 2'b01;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    PCWrite = 1'b1;
                    NPCOp   = Zero ? 3'b001 : 3'b000;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        PCWrite = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    cause_d = 2'b10;
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                if (is_jal)
                    NPCOp = 3'b010;
                else if (is_jalr)
                    NPCOp = 3'b100;
                state_d = S_FETCH;
            end
            default: state_d = S_TRAP;
        endcase
        if (rst) begin
            mem_req  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IorD     = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            NPCOp    = 3'b000;
        end
    end

    // Wait counter restarts on each fresh entry to a memory state and saturates.
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
            wait_d = '0;
        else if (mem_req && !mem_ready && (wait_q != {WAIT_W{1'b1}}))
            wait_d = wait_q + 1'b1;
    end

    // State, cause, wait counter and retire counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            if (PCWrite)
                retired_q <= retired_q + 1'b1;
        end
    end

    assign state      = rst ? 3'd0 : state_q;
    assign trap       = !rst && (state_q == S_TRAP);
    assign trap_cause = rst ? 2'b00 : cause_q;
    assign retired    = rst ? '0 : retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl with MEM_TIMEOUT=4 and a 3-bit retire counter.
// Inputs change #1 after the rising edge; outputs are checked #1 later, clear of the edge.
// Expected values are hand-derived from the state sequence of each instruction.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op, Funct7;
    logic [2:0] Funct3;
    logic       Zero, mem_ready;
    logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite;
    logic [5:0] EXTOp;
    logic [4:0] ALUOp;
    logic [2:0] NPCOp;
    logic       ALUSrc;
    logic [1:0] WDSel;
    logic [2:0] state;
    logic       trap;
    logic [1:0] trap_cause;
    logic [2:0] retired;

    int n_chk  = 0;
    int n_fail = 0;

    mc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct7(Funct7), .Funct3(Funct3),
        .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemRead(MemRead),
        .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
        .ALUSrc(ALUSrc), .WDSel(WDSel), .state(state), .trap(trap),
        .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3);
        Op = op;
        Funct7 = f7;
        Funct3 = f3;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // op, funct7, funct3, EXTOp, ALUOp, ALUSrc
    typedef struct packed {
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [5:0] ext;
        logic [4:0] alu;
        logic       src;
    } dec_vec_t;

    dec_vec_t dec_tab [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_tab[0] = '{7'b0010011, 7'h20, 3'h5, 6'b100000, 5'd17, 1'b1}; // srai
        dec_tab[1] = '{7'b0000011, 7'h00, 3'h2, 6'b010000, 5'd3,  1'b1}; // lw
        dec_tab[2] = '{7'b0110011, 7'h20, 3'h0, 6'b000000, 5'd4,  1'b0}; // sub
        dec_tab[3] = '{7'b1100011, 7'h00, 3'h6, 6'b000100, 5'd8,  1'b0}; // bltu
        dec_tab[4] = '{7'b0010011, 7'h00, 3'h3, 6'b010000, 5'd11, 1'b1}; // sltiu

        rst = 1'b1; Zero = 1'b0; mem_ready = 1'b0;
        set_ins(7'h00, 7'h00, 3'h0);
        tick(); tick();

        // Reset state
        check("rst_state",   state, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_pcwrite", PCWrite, 0);
        check("rst_trap",    trap, 0);
        check("rst_cause",   trap_cause, 0);
        check("rst_retired", retired, 0);

        // Decode is combinational in every state
        for (int i = 0; i < 5; i++) begin
            set_ins(dec_tab[i].op, dec_tab[i].f7, dec_tab[i].f3);
            #1;
            check("dec_ext", EXTOp, dec_tab[i].ext);
            check("dec_alu", ALUOp, dec_tab[i].alu);
            check("dec_src", ALUSrc, dec_tab[i].src);
        end

        // add x3,x1,x2 zero-wait
        set_ins(7'b0110011, 7'h00, 3'h0);
        rst = 1'b0; mem_ready = 1'b1; #1;
        check("add_f_state", state, 0);
        check("add_f_req",   mem_req, 1);
        check("add_f_ir",    IRWrite, 1);
        check("add_f_iord",  IorD, 0);
        tick();
        check("add_d_state", state, 1);
        check("add_d_rw",    RegWrite, 0);
        tick();
        check("add_e_state", state, 2);
        check("add_e_rw",    RegWrite, 0);
        tick();
        check("add_w_state", state, 4);
        check("add_w_rw",    RegWrite, 1);
        check("add_w_pcw",   PCWrite, 1);
        check("add_w_wdsel", WDSel, 0);
        check("add_w_alu",   ALUOp, 3);
        check("add_w_ret",   retired, 0);
        tick();
        check("add_done_state", state, 0);
        check("add_done_ret",   retired, 1);

        // lw with three wait cycles in MEM
        set_ins(7'b0000011, 7'h00, 3'h2);
        tick(); tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lw_m_state", state, 3);
            check("lw_m_req",   mem_req, 1);
            check("lw_m_iord",  IorD, 1);
            check("lw_m_rd",    MemRead, 1);
            check("lw_m_wr",    MemWrite, 0);
        end
        tick();
        mem_ready = 1'b1; #1;
        check("lw_m4_state", state, 3);
        check("lw_m4_req",   mem_req, 1);
        tick();
        check("lw_w_state", state, 4);
        check("lw_w_wdsel", WDSel, 1);
        check("lw_w_rw",    RegWrite, 1);
        tick();
        check("lw_done_state", state, 0);
        check("lw_done_ret",   retired, 2);

        // beq taken then not taken
        set_ins(7'b1100011, 7'h00, 3'h0);
        for (int z = 1; z >= 0; z--) begin
            tick();
            check("beq_d_rw", RegWrite, 0);
            tick();
            Zero = z[0]; #1;
            check("beq_e_state", state, 2);
            check("beq_e_pcw",   PCWrite, 1);
            check("beq_e_npc",   NPCOp, (z == 1) ? 1 : 0);
            check("beq_e_alu",   ALUOp, 4);
            check("beq_e_rw",    RegWrite, 0);
            tick();
            check("beq_done_state", state, 0);
        end
        check("beq_ret", retired, 4);
        Zero = 1'b0;

        // sw zero-wait
        set_ins(7'b0100011, 7'h00, 3'h2);
        tick(); tick(); tick();
        check("sw_m_state", state, 3);
        check("sw_m_wr",    MemWrite, 1);
        check("sw_m_rd",    MemRead, 0);
        check("sw_m_pcw",   PCWrite, 1);
        check("sw_m_npc",   NPCOp, 0);
        check("sw_m_ext",   EXTOp, 6'b001000);
        tick();
        check("sw_done_state", state, 0);
        check("sw_done_ret",   retired, 5);

        // jal with ready arriving on the 4th fetch cycle (limit cycle) -> no trap
        set_ins(7'b1101111, 7'h00, 3'h0);
        mem_ready = 1'b0; #1;
        tick(); tick(); tick();
        check("lim_f_state", state, 0);
        check("lim_f_req",   mem_req, 1);
        mem_ready = 1'b1; #1;
        tick();
        check("lim_state", state, 1);
        check("lim_trap",  trap, 0);
        tick(); tick();
        check("jal_w_npc",   NPCOp, 3'b010);
        check("jal_w_wdsel", WDSel, 2);
        tick();
        check("jal_ret", retired, 6);

        // Fetch timeout: ready stuck low for 4 cycles
        mem_ready = 1'b0; #1;
        tick(); tick(); tick();
        check("to_pre_state", state, 0);
        tick();
        check("to_state", state, 5);
        check("to_trap",  trap, 1);
        check("to_cause", trap_cause, 2);
        check("to_req",   mem_req, 0);
        mem_ready = 1'b1;
        tick();
        check("to_hold_state", state, 5);
        rst_pulse();
        check("to_rst_trap", trap, 0);
        check("to_rst_ret",  retired, 0);

        // Nine back-to-back jal: counter wraps 7 -> 0 -> 1
        set_ins(7'b1101111, 7'h00, 3'h0);
        for (int i = 1; i <= 9; i++) begin
            tick(); tick(); tick(); tick();
            check("wrap_ret", retired, i % 8);
        end

        // Reset in the MEM cycle of a stalled sw
        set_ins(7'b0100011, 7'h00, 3'h2);
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        check("swr_m_state", state, 3);
        check("swr_m_wr",    MemWrite, 1);
        rst = 1'b1; #1;
        check("swr_rst_wr",  MemWrite, 0);
        check("swr_rst_pcw", PCWrite, 0);
        tick();
        check("swr_state", state, 0);
        check("swr_ret",   retired, 0);
        rst = 1'b0;
        tick();
        check("swr_after_wr",    MemWrite, 0);
        check("swr_after_state", state, 0);
        check("swr_after_ret",   retired, 0);
        rst_pulse();

        // Illegal opcode 0x7F, then R-type with funct7=0x01
        mem_ready = 1'b1;
        set_ins(7'h7F, 7'h00, 3'h0);
        tick();
        check("ill_d_state", state, 1);
        tick();
        check("ill_state", state, 5);
        check("ill_trap",  trap, 1);
        check("ill_cause", trap_cause, 1);
        tick(); tick(); tick();
        check("ill_hold_state", state, 5);
        check("ill_hold_pcw",   PCWrite, 0);
        check("ill_hold_ret",   retired, 0);
        rst_pulse();

        set_ins(7'b0110011, 7'h01, 3'h0);
        tick(); tick();
        check("mul_state", state, 5);
        check("mul_cause", trap_cause, 1);
        check("mul_pcw",   PCWrite, 0);
        rst_pulse();
        check("mul_rst_state", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
